// File: rtl/fsqrt_sched_pkg.sv
// rtl/fsqrt_sched_pkg.sv - shared widths, tag type and helpers for the fsqrt scheduler
package fsqrt_sched_pkg;

  // Operand / result width of the floating-point unit.
  localparam int FP_W = 32;

  // Largest requester count the scheduler family supports.
  localparam int MAX_REQ = 8;

  // Width of a requester index: at least one bit even for a single pair.
  function automatic int id_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  // Tag ids are sized for the largest supported requester count so the
  // same tag type serves every instance; smaller instances zero-extend.
  localparam int ID_W = id_width(MAX_REQ);

  typedef struct packed {
    logic            valid;
    logic [ID_W-1:0] id;
  } tag_t;

endpackage

// File: rtl/fsqrt_sched_rr_arbiter.sv
// rtl/fsqrt_sched_rr_arbiter.sv - combinational round-robin arbiter with external pointer
module rr_arbiter
  import fsqrt_sched_pkg::*;
#(
  parameter  int N  = 4,
  localparam int PW = id_width(N)
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  output logic [N-1:0]  grant
);

  logic [PW-1:0] idx;
  logic          found;

  // Scan from ptr+1 upward with wrap and grant the first requester found.
  always_comb begin
    grant = '0;
    found = 1'b0;
    idx   = '0;
    for (int k = 1; k <= N; k++) begin
      idx = PW'((int'(ptr) + k) % N);
      if (!found && req[idx]) begin
        grant[idx] = 1'b1;
        found      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/fsqrt_sched.sv
// rtl/fsqrt_sched.sv - shares one pipelined fsqrt unit between several requesters
module fsqrt_sched
  import fsqrt_sched_pkg::*;
#(
  parameter int N_REQ   = 4,
  parameter int LATENCY = 3
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [N_REQ-1:0]      req_valid,
  input  logic [N_REQ*FP_W-1:0] req_op,
  output logic [N_REQ-1:0]      req_ready,
  output logic [N_REQ-1:0]      resp_valid,
  output logic [FP_W-1:0]       resp_data,
  output logic [FP_W-1:0]       sq_op,
  input  logic [FP_W-1:0]       sq_result,
  output logic                  busy
);

  localparam int PW = id_width(N_REQ);

  logic [PW-1:0]    rr_ptr;
  logic [N_REQ-1:0] outstanding;
  logic [N_REQ-1:0] eligible;
  logic [N_REQ-1:0] grant;
  logic [N_REQ-1:0] accept_vec;
  logic [N_REQ-1:0] resp_hit;
  logic [PW-1:0]    gnt_id;
  logic [FP_W-1:0]  gnt_op;
  logic             accept;
  tag_t             tag_pipe [0:LATENCY];
  tag_t             tail;

  // A requester with a result still in flight may not issue again.
  assign eligible = req_valid & ~outstanding;

  rr_arbiter #(.N(N_REQ)) u_arb (
    .req   (eligible),
    .ptr   (rr_ptr),
    .grant (grant)
  );

  assign req_ready  = reset ? '0 : grant;
  assign accept_vec = req_valid & req_ready;
  assign accept     = |accept_vec;

  // Encode the one-hot grant into an index and select that operand.
  always_comb begin
    gnt_id = '0;
    gnt_op = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (grant[i]) begin
        gnt_id = PW'(i);
        gnt_op = req_op[i*FP_W +: FP_W];
      end
    end
  end

  // Operand register feeding fsqrt; holds its value when nothing issues.
  always_ff @(posedge clk) begin
    if (reset) begin
      sq_op <= '0;
    end else if (accept) begin
      sq_op <= gnt_op;
    end
  end

  // Round-robin pointer remembers the most recent winner.
  always_ff @(posedge clk) begin
    if (reset) begin
      rr_ptr <= PW'(N_REQ - 1);
    end else if (accept) begin
      rr_ptr <= gnt_id;
    end
  end

  // Owner tags shadow the fsqrt pipeline; the tail lines up with sq_result.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i <= LATENCY; i++) begin
        tag_pipe[i] <= '0;
      end
    end else begin
      tag_pipe[0].valid <= accept;
      tag_pipe[0].id    <= accept ? ID_W'(gnt_id) : '0;
      for (int i = 1; i <= LATENCY; i++) begin
        tag_pipe[i] <= tag_pipe[i-1];
      end
    end
  end

  assign tail = tag_pipe[LATENCY];

  // Decode the tail tag into a per-requester response strobe.
  always_comb begin
    resp_hit = '0;
    for (int i = 0; i < N_REQ; i++) begin
      resp_hit[i] = tail.valid && (tail.id == ID_W'(i));
    end
  end

  assign resp_valid = reset ? '0 : resp_hit;
  assign resp_data  = sq_result;

  // In-flight bits: set on accept, released once the response has been shown.
  always_ff @(posedge clk) begin
    if (reset) begin
      outstanding <= '0;
    end else begin
      outstanding <= (outstanding & ~resp_hit) | accept_vec;
    end
  end

  assign busy = |outstanding;

endmodule

// File: tb/tb_fsqrt_sched.sv
// tb/tb_fsqrt_sched.sv - scoreboard bench for the fsqrt scheduler
module tb_fsqrt_sched;

  localparam int N   = 4;
  localparam int LAT = 3;

  logic            clk = 1'b0;
  logic            reset = 1'b1;
  logic [N-1:0]    req_valid = '0;
  logic [N*32-1:0] req_op = '0;
  logic [N-1:0]    req_ready;
  logic [N-1:0]    resp_valid;
  logic [31:0]     resp_data;
  logic [31:0]     sq_op;
  logic [31:0]     sq_result;
  logic            busy;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  typedef struct {
    int          id;
    logic [31:0] data;
    int          due;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   acc_id[$];
  int   acc_cyc[$];

  logic [31:0] ops2  [4] = '{32'h3F800000, 32'h40800000, 32'h41100000, 32'h41800000};
  logic [31:0] exp2  [4] = '{32'h3F800000, 32'h40000000, 32'h40400000, 32'h40800000};
  int          fair_id [6] = '{0, 2, 0, 2, 0, 2};
  int          fair_gap[6] = '{0, 1, 5, 6, 10, 11};

  fsqrt_sched #(.N_REQ(N), .LATENCY(LAT)) dut (
    .clk        (clk),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_op     (req_op),
    .req_ready  (req_ready),
    .resp_valid (resp_valid),
    .resp_data  (resp_data),
    .sq_op      (sq_op),
    .sq_result  (sq_result),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] sqrt_ref(input logic [31:0] x);
    case (x)
      32'h3F800000: sqrt_ref = 32'h3F800000;
      32'h40800000: sqrt_ref = 32'h40000000;
      32'h41100000: sqrt_ref = 32'h40400000;
      32'h41800000: sqrt_ref = 32'h40800000;
      32'h00000000: sqrt_ref = 32'h00000000;
      32'h80000000: sqrt_ref = 32'h80000000;
      default:      sqrt_ref = x ^ 32'h00A55A00;
    endcase
  endfunction

  // External fsqrt unit: LAT register stages, not affected by scheduler reset.
  logic [31:0] fs_pipe [0:LAT-1];
  always @(posedge clk) begin
    fs_pipe[0] <= sqrt_ref(sq_op);
    for (int k = 1; k < LAT; k++) fs_pipe[k] <= fs_pipe[k-1];
  end
  assign sq_result = fs_pipe[LAT-1];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h cycle=%0d", tag, got, exp, cyc);
    end
  endtask

  // Scoreboard: push on accept, pop and compare on response.
  always @(negedge clk) begin
    if (reset) begin
      sb.delete();
    end else begin
      chk("ready_subset", 32'(req_ready & ~req_valid), 32'd0);
      chk("ready_onehot", 32'($countones(req_ready) <= 1), 32'd1);
      if (resp_valid != '0) begin
        if (sb.size() == 0) begin
          chk("spurious_resp", 32'(resp_valid), 32'd0);
        end else begin
          mon_e = sb.pop_front();
          chk("resp_owner", 32'(resp_valid), 32'(1 << mon_e.id));
          chk("resp_data", resp_data, mon_e.data);
          chk("resp_cycle", cyc, mon_e.due);
        end
      end else if (sb.size() > 0 && sb[0].due <= cyc) begin
        mon_e = sb.pop_front();
        chk("resp_missing", 32'(resp_valid), 32'(1 << mon_e.id));
      end
      for (int i = 0; i < N; i++) begin
        if (req_valid[i] && req_ready[i]) begin
          sb.push_back('{i, sqrt_ref(req_op[i*32 +: 32]), cyc + LAT + 1});
          acc_id.push_back(i);
          acc_cyc.push_back(cyc);
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    req_valid = '0;
    step();
    step();
    reset = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (busy !== 1'b0 && n < 64) begin
      step();
      n++;
    end
    step();
    #1;
    chk("drain_busy", 32'(busy), 32'd0);
  endtask

  task automatic single(input int id, input logic [31:0] op, input logic [31:0] exp);
    req_op[id*32 +: 32] = op;
    req_valid[id] = 1'b1;
    #1;
    chk("single_ready", 32'(req_ready), 32'(1 << id));
    step();
    req_valid[id] = 1'b0;
    repeat (3) step();
    #1;
    chk("single_resp_valid", 32'(resp_valid), 32'(1 << id));
    chk("single_resp_data", resp_data, exp);
    chk("single_passthru", resp_data, sq_result);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // Reset values, with requests present during reset.
    reset = 1'b1;
    req_valid = '1;
    req_op = {32'h41800000, 32'h41100000, 32'h40800000, 32'h3F800000};
    repeat (3) step();
    #1;
    chk("rst_ready", 32'(req_ready), 32'd0);
    chk("rst_resp_valid", 32'(resp_valid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_sq_op", sq_op, 32'd0);
    reset = 1'b0;
    req_valid = '0;
    repeat (3) step();

    // Single requester: fixed latency and busy window.
    req_op[31:0] = 32'h40800000;
    req_valid[0] = 1'b1;
    #1;
    chk("t1_ready", 32'(req_ready), 32'd1);
    step();
    req_valid[0] = 1'b0;
    for (int k = 1; k <= 5; k++) begin
      #1;
      chk("t1_busy", 32'(busy), 32'(k <= 4));
      chk("t1_resp_valid", 32'(resp_valid), (k == 4) ? 32'd1 : 32'd0);
      if (k == 4) chk("t1_resp_data", resp_data, 32'h40000000);
      step();
    end

    // All four at once after reset: issue and return in order 0..3.
    do_reset();
    for (int k = 0; k < 4; k++) req_op[k*32 +: 32] = ops2[k];
    req_valid = '1;
    for (int k = 0; k < 4; k++) begin
      #1;
      chk("t2_grant_order", 32'(req_ready), 32'(1 << k));
      step();
      req_valid[k] = 1'b0;
    end
    for (int k = 0; k < 4; k++) begin
      #1;
      chk("t2_resp_owner", 32'(resp_valid), 32'(1 << k));
      chk("t2_resp_data", resp_data, exp2[k]);
      step();
    end
    drain();

    // Fairness between two continuously valid requesters.
    acc_id.delete();
    acc_cyc.delete();
    req_op[31:0] = 32'h3F800000;
    req_op[95:64] = 32'h41800000;
    req_valid = 4'b0101;
    repeat (12) step();
    req_valid = '0;
    drain();
    chk("t3_accept_count", 32'(acc_id.size()), 32'd6);
    if (acc_id.size() >= 6) begin
      for (int k = 0; k < 6; k++) begin
        chk("t3_fair_id", 32'(acc_id[k]), 32'(fair_id[k]));
        chk("t3_fair_gap", 32'(acc_cyc[k] - acc_cyc[0]), 32'(fair_gap[k]));
      end
    end

    // Re-request blocked until the cycle after the own response.
    req_op[63:32] = 32'h41800000;
    req_valid[1] = 1'b1;
    #1;
    chk("t4_first_ready", 32'(req_ready), 32'b0010);
    step();
    for (int k = 1; k <= 5; k++) begin
      #1;
      chk("t4_rereq_ready", 32'(req_ready[1]), 32'(k == 5));
      step();
    end
    req_valid[1] = 1'b0;
    drain();

    // Reset two cycles after an accept: the draining result must be dropped.
    req_op[127:96] = 32'h41100000;
    req_valid[3] = 1'b1;
    #1;
    chk("t5_ready", 32'(req_ready), 32'b1000);
    step();
    req_valid[3] = 1'b0;
    step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    #1;
    chk("t5_busy_cleared", 32'(busy), 32'd0);
    chk("t5_ready_cleared", 32'(req_ready), 32'd0);
    chk("t5_resp_cleared", 32'(resp_valid), 32'd0);
    for (int k = 0; k < 5; k++) begin
      step();
      #1;
      chk("t5_no_resp", 32'(resp_valid), 32'd0);
    end
    step();
    single(3, 32'h41100000, 32'h40400000);
    step();

    // Zero, negative zero and an arbitrary pattern pass through untouched.
    single(2, 32'h00000000, 32'h00000000);
    step();
    single(2, 32'h80000000, 32'h80000000);
    step();
    single(0, 32'hC0800000, sqrt_ref(32'hC0800000));
    drain();
    chk("sb_empty", 32'(sb.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
